// File: rtl/seven_seg_sched.sv
// Scan/ownership scheduler for a 4-digit seven-segment driver: digit scan index,
// blink clock and frame-aligned arbitration of two requesters. Define
// SEVEN_SEG_SCHED_FLASH_EN to build the blink clock; otherwise flash_clk and blinking are 0.
module seven_seg_sched #(
  parameter int SCAN_DIV     = 50000,
  parameter int FLASH_FRAMES = 64,
  parameter int MIN_FRAMES   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] num0,
  input  logic [31:0] num1,
  input  logic [1:0]  mode0,
  input  logic [1:0]  mode1,
  input  logic [3:0]  point0,
  input  logic [3:0]  point1,
  input  logic [3:0]  blink0,
  input  logic [3:0]  blink1,
  output logic [31:0] disp_num,
  output logic [1:0]  SW,
  output logic [3:0]  pointing,
  output logic [3:0]  blinking,
  output logic [1:0]  Scanning,
  output logic        flash_clk,
  output logic [1:0]  grant,
  output logic        frame_end,
  output logic [1:0]  o_dbg_state
);

  // Handshake: none. req is a level sampled only on the frame_end cycle; grant
  // and the latched content change together on the edge that closes that cycle.

  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HC_W = (MIN_FRAMES > 1) ? $clog2(MIN_FRAMES) : 1;
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_DIV - 1);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(MIN_FRAMES - 1);

`ifdef SEVEN_SEG_SCHED_FLASH_EN
  localparam logic [3:0] BLINK_MASK = 4'hF;
`else
  localparam logic [3:0] BLINK_MASK = 4'h0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  logic [SC_W-1:0] r_sc;
  logic [1:0]      r_scan;
  logic            w_tick;
  logic            w_frame_end;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HC_W-1:0] r_hc;
  logic [HC_W-1:0] w_hc_nxt;
  logic            r_last;
  logic            w_last_nxt;
  logic            w_own_idx;
  logic            w_req_self;
  logic            w_req_other;

  logic [1:0]      r_grant;
  logic [31:0]     r_num;
  logic [1:0]      r_sw;
  logic [3:0]      r_point;
  logic [3:0]      r_blink;
  logic [1:0]      w_grant_nxt;
  logic [31:0]     w_num_nxt;
  logic [1:0]      w_sw_nxt;
  logic [3:0]      w_point_nxt;
  logic [3:0]      w_blink_nxt;

  assign w_tick      = (r_sc == SC_MAX);
  assign w_frame_end = w_tick && (r_scan == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc   <= '0;
      r_scan <= 2'd0;
    end else if (w_tick) begin
      r_sc   <= '0;
      r_scan <= r_scan + 2'd1;
    end else begin
      r_sc   <= r_sc + SC_W'(1);
    end
  end

`ifdef SEVEN_SEG_SCHED_FLASH_EN
  localparam int FL_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FL_W-1:0] FL_MAX = FL_W'(FLASH_FRAMES - 1);

  logic [FL_W-1:0] r_flash_cnt;
  logic            r_flash_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flash_cnt <= '0;
      r_flash_clk <= 1'b0;
    end else if (w_frame_end) begin
      if (r_flash_cnt == FL_MAX) begin
        r_flash_cnt <= '0;
        r_flash_clk <= ~r_flash_clk;
      end else begin
        r_flash_cnt <= r_flash_cnt + FL_W'(1);
      end
    end
  end

  assign flash_clk = r_flash_clk;
`else
  assign flash_clk = 1'b0;
`endif

  // State register: the arbiter only advances on the last cycle of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hc    <= '0;
      r_last  <= 1'b1;
    end else if (w_frame_end) begin
      r_state <= w_state_nxt;
      r_hc    <= w_hc_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign w_own_idx   = (r_state == ST_OWN1);
  assign w_req_self  = w_own_idx ? req[1] : req[0];
  assign w_req_other = w_own_idx ? req[0] : req[1];

  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        w_hc_nxt = '0;
        if (req == 2'b11) begin
          w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
        end else if (req[0]) begin
          w_state_nxt = ST_OWN0;
        end else if (req[1]) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (r_hc != HC_MAX) begin
          w_hc_nxt = r_hc + HC_W'(1);
        end else if (w_req_other) begin
          w_state_nxt = w_own_idx ? ST_OWN0 : ST_OWN1;
          w_hc_nxt    = '0;
          w_last_nxt  = w_own_idx;
        end else if (!w_req_self) begin
          w_state_nxt = ST_IDLE;
          w_hc_nxt    = '0;
          w_last_nxt  = w_own_idx;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hc_nxt    = '0;
      end
    endcase
  end

  // Output selection follows the state being entered, so a new owner's first
  // visible digit already carries its content.
  always_comb begin
    w_grant_nxt = 2'b00;
    w_num_nxt   = 32'h0;
    w_sw_nxt    = 2'b01;
    w_point_nxt = 4'hF;
    w_blink_nxt = 4'h0;
    case (w_state_nxt)
      ST_OWN0: begin
        w_grant_nxt = 2'b01;
        w_num_nxt   = num0;
        w_sw_nxt    = mode0;
        w_point_nxt = point0;
        w_blink_nxt = blink0 & BLINK_MASK;
      end
      ST_OWN1: begin
        w_grant_nxt = 2'b10;
        w_num_nxt   = num1;
        w_sw_nxt    = mode1;
        w_point_nxt = point1;
        w_blink_nxt = blink1 & BLINK_MASK;
      end
      default: begin
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= 2'b00;
      r_num   <= 32'h0;
      r_sw    <= 2'b01;
      r_point <= 4'hF;
      r_blink <= 4'h0;
    end else if (w_frame_end) begin
      r_grant <= w_grant_nxt;
      r_num   <= w_num_nxt;
      r_sw    <= w_sw_nxt;
      r_point <= w_point_nxt;
      r_blink <= w_blink_nxt;
    end
  end

  assign disp_num    = r_num;
  assign SW          = r_sw;
  assign pointing    = r_point;
  assign blinking    = r_blink;
  assign Scanning    = r_scan;
  assign grant       = r_grant;
  assign frame_end   = w_frame_end;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seven_seg_sched.sv
// Self-checking bench for seven_seg_sched with SCAN_DIV=2, FLASH_FRAMES=2,
// MIN_FRAMES=2 (8-cycle frames); expectations adapt to SEVEN_SEG_SCHED_FLASH_EN.
module tb_seven_seg_sched;

  localparam int SCAN_DIV     = 2;
  localparam int FLASH_FRAMES = 2;
  localparam int MIN_FRAMES   = 2;
  localparam int FRAME        = 4 * SCAN_DIV;
  localparam int OUT_W        = 44;

`ifdef SEVEN_SEG_SCHED_FLASH_EN
  localparam logic [3:0] BL_MASK  = 4'hF;
  localparam bit         FLASH_ON = 1'b1;
`else
  localparam logic [3:0] BL_MASK  = 4'h0;
  localparam bit         FLASH_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] num0, num1;
  logic [1:0]  mode0, mode1;
  logic [3:0]  point0, point1, blink0, blink1;
  logic [31:0] disp_num;
  logic [1:0]  SW, Scanning, grant, dbg_state;
  logic [3:0]  pointing, blinking;
  logic        flash_clk, frame_end;

  always #5 clk = ~clk;

  seven_seg_sched #(
    .SCAN_DIV(SCAN_DIV), .FLASH_FRAMES(FLASH_FRAMES), .MIN_FRAMES(MIN_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .num0(num0), .num1(num1), .mode0(mode0), .mode1(mode1),
    .point0(point0), .point1(point1), .blink0(blink0), .blink1(blink1),
    .disp_num(disp_num), .SW(SW), .pointing(pointing), .blinking(blinking),
    .Scanning(Scanning), .flash_clk(flash_clk), .grant(grant),
    .frame_end(frame_end), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_grant;
  } vec_t;

  function automatic logic [OUT_W-1:0] pack(input logic [1:0] g, input logic [31:0] n,
                                            input logic [1:0] s, input logic [3:0] p,
                                            input logic [3:0] b);
    return {g, s, p, b, n};
  endfunction

  // Content expected on the display for a given owner, for table frame i.
  function automatic logic [OUT_W-1:0] exp_content(input logic [1:0] g, input int i);
    case (g)
      2'b01:   return pack(2'b01, 32'hA000_0000 + 32'(i), 2'b10, 4'h5, 4'h3 & BL_MASK);
      2'b10:   return pack(2'b10, 32'hB000_0000 + 32'(i), 2'b11, 4'hA, 4'hC & BL_MASK);
      default: return pack(2'b00, 32'h0, 2'b01, 4'hF, 4'h0);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_check(input string name);
    logic [OUT_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, " (scoreboard empty)"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(pack(grant, disp_num, SW, pointing, blinking)), 64'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; num0 = 32'h0; num1 = 32'h0; mode0 = 2'b00; mode1 = 2'b00;
    point0 = 4'h0; point1 = 4'h0; blink0 = 4'h0; blink1 = 4'h0;
  endtask

  // Leaves rst low at the start of cycle 1.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic drive_junk();
    req    = 2'($urandom_range(0, 3));
    num0   = $urandom;
    num1   = $urandom;
    mode0  = 2'($urandom_range(0, 3));
    mode1  = 2'($urandom_range(0, 3));
    point0 = 4'($urandom_range(0, 15));
    point1 = 4'($urandom_range(0, 15));
    blink0 = 4'($urandom_range(0, 15));
    blink1 = 4'($urandom_range(0, 15));
  endtask

  task automatic drive_frame(input logic [1:0] r, input int i);
    req = r;
    num0 = 32'hA000_0000 + 32'(i); num1 = 32'hB000_0000 + 32'(i);
    mode0 = 2'b10; mode1 = 2'b11;
    point0 = 4'h5; point1 = 4'hA;
    blink0 = 4'h3; blink1 = 4'hC;
  endtask

  // ---------------- tests ----------------
  initial begin
    vec_t vecs[17];
    logic [OUT_W-1:0] prev;
    int fe_at;

    idle_inputs();
    rst = 1'b1;

    // Reset: requests and content present during reset must not leak through.
    req = 2'b11; num0 = 32'hDEAD_BEEF; num1 = 32'hCAFE_F00D; blink0 = 4'hF;
    repeat (3) step();
    check("rst Scanning", 64'(Scanning), 64'd0);
    check("rst frame_end", 64'(frame_end), 64'd0);
    check("rst flash_clk", 64'(flash_clk), 64'd0);
    check("rst state", 64'(dbg_state), 64'd0);
    exp_q.push_back(pack(2'b00, 32'h0, 2'b01, 4'hF, 4'h0));
    sb_check("rst outputs");

    // Scan sequence plus a single request raised in cycle 3.
    idle_inputs();
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) begin
        req = 2'b01; num0 = 32'h1234_5678; mode0 = 2'b10; point0 = 4'h7; blink0 = 4'h9;
      end
      check($sformatf("scan c%0d", c), 64'(Scanning), 64'(((c - 1) / SCAN_DIV) % 4));
      check($sformatf("frame_end c%0d", c), 64'(frame_end), 64'(c == FRAME));
      if (c >= 3 && c <= 8) begin
        exp_q.push_back(pack(2'b00, 32'h0, 2'b01, 4'hF, 4'h0));
        sb_check($sformatf("single hold c%0d", c));
      end
      if (c == 9) begin
        exp_q.push_back(pack(2'b01, 32'h1234_5678, 2'b10, 4'h7, 4'h9 & BL_MASK));
        sb_check("single grant c9");
      end
      if (c < 9) step();
    end

    // Simultaneous requests from reset: 0 first, 1 after the hold.
    idle_inputs();
    req = 2'b11; num0 = 32'h0000_AAAA; num1 = 32'h0000_BBBB; mode0 = 2'b00; mode1 = 2'b11;
    do_reset(2);
    repeat (FRAME - 1) step();
    check("simul c8 frame_end", 64'(frame_end), 64'd1);
    check("simul c8 grant", 64'(grant), 64'd0);
    step();
    check("simul c9 grant", 64'(grant), 64'b01);
    check("simul c9 disp", 64'(disp_num), 64'h0000_AAAA);
    repeat (FRAME) step();
    check("simul c17 grant", 64'(grant), 64'b01);
    repeat (FRAME - 1) step();
    check("simul c24 grant", 64'(grant), 64'b01);
    check("simul c24 Scanning", 64'(Scanning), 64'd3);
    step();
    check("simul c25 grant", 64'(grant), 64'b10);
    check("simul c25 disp", 64'(disp_num), 64'h0000_BBBB);
    check("simul c25 Scanning", 64'(Scanning), 64'd0);

    // Release before the hold expires.
    idle_inputs();
    req = 2'b01; num0 = 32'h5555_0000; point0 = 4'h3;
    do_reset(2);
    repeat (FRAME) step();
    check("release c9 grant", 64'(grant), 64'b01);
    req = 2'b00;
    repeat (FRAME) step();
    check("release c17 grant", 64'(grant), 64'b01);
    repeat (FRAME) step();
    exp_q.push_back(pack(2'b00, 32'h0, 2'b01, 4'hF, 4'h0));
    sb_check("release c25 idle");

    // Frame-level vector table; inputs are scrambled except on the frame_end cycle.
    vecs = '{
      '{2'b00, 2'b00}, '{2'b01, 2'b01}, '{2'b11, 2'b01}, '{2'b11, 2'b10},
      '{2'b10, 2'b10}, '{2'b00, 2'b00}, '{2'b11, 2'b01}, '{2'b10, 2'b01},
      '{2'b10, 2'b10}, '{2'b00, 2'b10}, '{2'b00, 2'b00}, '{2'b10, 2'b10},
      '{2'b10, 2'b10}, '{2'b11, 2'b01}, '{2'b00, 2'b01}, '{2'b00, 2'b00},
      '{2'b11, 2'b10}
    };
    idle_inputs();
    do_reset(2);
    prev = exp_content(2'b00, 0);
    for (int i = 0; i < 17; i++) begin
      for (int k = 1; k <= FRAME; k++) begin
        if (k < FRAME) drive_junk();
        else drive_frame(vecs[i].req, i);
        if (k == FRAME) check($sformatf("vec%0d frame_end", i), 64'(frame_end), 64'd1);
        step();
        if (k < FRAME) begin
          exp_q.push_back(prev);
          sb_check($sformatf("vec%0d hold k%0d", i, k + 1));
        end
      end
      prev = exp_content(vecs[i].exp_grant, i);
      exp_q.push_back(prev);
      sb_check($sformatf("vec%0d frame", i));
    end

    // Flash clock while idle, then blink masking while owned.
    idle_inputs();
    do_reset(2);
    for (int c = 1; c <= 8 * FRAME; c++) begin
      check($sformatf("flash c%0d", c), 64'(flash_clk),
            FLASH_ON ? 64'(((c - 1) / (2 * FRAME)) % 2) : 64'd0);
      if (c < 8 * FRAME) step();
    end
    req = 2'b01; blink0 = 4'hF;
    repeat (FRAME) step();
    check("blink grant", 64'(grant), 64'b01);
    check("blink value", 64'(blinking), 64'(4'hF & BL_MASK));

    // Mid-frame reset while owned, with flash_clk high in the flash build.
    idle_inputs();
    req = 2'b01; num0 = 32'h7777_7777;
    do_reset(2);
    repeat (20) step();
    check("midrst pre Scanning", 64'(Scanning), 64'd2);
    check("midrst pre grant", 64'(grant), 64'b01);
    check("midrst pre flash", 64'(flash_clk), 64'(FLASH_ON));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst Scanning", 64'(Scanning), 64'd0);
    check("midrst grant", 64'(grant), 64'd0);
    check("midrst flash", 64'(flash_clk), 64'd0);
    check("midrst disp", 64'(disp_num), 64'd0);
    fe_at = 0;
    for (int c = 1; c <= 2 * FRAME && fe_at == 0; c++) begin
      if (frame_end) fe_at = c;
      else step();
    end
    check("midrst first frame_end cycle", 64'(fe_at), 64'(FRAME));

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
